// File: rtl/btn_event.sv
// Button event classifier: debounced active-low level in, one-cycle click / double_click / long_press strobes out.
// All outputs registered (one cycle after the deciding sample); `define BTN_AUTOREPEAT_EN adds repeat_pulse while held.
module btn_event #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned GAP_CYCLES    = 6_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_400_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic pressed,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYCLES);

  // A cycle count that does not fit the counter would silently truncate.
  if (((64'(LONG_CYCLES) >> CNT_W) != 0) || ((64'(GAP_CYCLES) >> CNT_W) != 0) ||
      ((64'(REPEAT_CYCLES) >> CNT_W) != 0)) begin : g_cfg_err
    $error("btn_event: cycle parameter does not fit in CNT_W bits");
  end

  state_t           state;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      cnt          <= '0;
      pressed      <= 1'b0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_pulse <= 1'b0;
`endif
    end else begin
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_pulse <= 1'b0;
`endif
      // A button held through reset stays invisible until its first release.
      pressed <= armed & ~btn_level;
      if (btn_level) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && !btn_level) begin
            state <= PRESS1;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS1: begin
          if (!btn_level) begin
            if (cnt_inc >= LONG_C) begin
              long_press <= 1'b1;
              state      <= LONG;
              cnt        <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            state <= WAIT2;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT2: begin
          // A second press takes priority over the window closing on the same sample.
          if (!btn_level) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt_inc >= GAP_C) begin
            click <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESS2: begin
          if (btn_level) begin
            double_click <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LONG: begin
          if (btn_level) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (cnt_inc >= REPEAT_C) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt_inc;
            end
`else
            cnt <= cnt;
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Scoreboarded bench for btn_event: scenarios queue expected strobes (kind, edge); a negedge monitor pops and compares.
module tb_btn_event;

  localparam int LC = 20;
  localparam int GC = 10;
  localparam int RC = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_level;
  logic pressed, click, double_click, long_press, repeat_pulse;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb[$];

  btn_event #(
    .CNT_W(24),
    .LONG_CYCLES(LC),
    .GAP_CYCLES(GC),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_level(btn_level),
    .pressed(pressed),
    .click(click),
    .double_click(double_click),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(int k);
    case (k)
      0: return "click";
      1: return "double_click";
      2: return "long_press";
      default: return "repeat_pulse";
    endcase
  endfunction

  task automatic expect_ev(int k, int at);
    sb.push_back('{k, at});
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Each call starts at a negedge; one sample per following clock edge.
  task automatic seg(logic lvl, int n);
    for (int i = 0; i < n; i++) begin
      btn_level = lvl;
      @(negedge clk);
    end
  endtask

  // Monitor: outputs only move at posedge, so the negedge sees the strobe decided at edge edge_n.
  always @(negedge clk) begin : mon
    logic [3:0] st;
    int         k;
    exp_t       e;
    while (sb.size() > 0 && sb[0].at < edge_n) begin
      checks++;
      errors++;
      $display("FAIL missing %s: expected at edge %0d, not seen by edge %0d",
               kname(sb[0].kind), sb[0].at, edge_n);
      void'(sb.pop_front());
    end
    st = {repeat_pulse, long_press, double_click, click};
    if (st != 4'b0000) begin
      checks++;
      if ($countones(st) != 1) begin
        errors++;
        $display("FAIL multi_strobe: got strobes %b at edge %0d, required at most one", st, edge_n);
      end else begin
        k = st[0] ? 0 : st[1] ? 1 : st[2] ? 2 : 3;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected %s at edge %0d, required no strobe", kname(k), edge_n);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || e.at != edge_n) begin
            errors++;
            $display("FAIL strobe: got %s at edge %0d, expected %s at edge %0d",
                     kname(k), edge_n, kname(e.kind), e.at);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst_n     = 1'b0;
    btn_level = 1'b1;
    #3;
    check1("rst_pressed", pressed, 1'b0);
    check1("rst_click", click, 1'b0);
    check1("rst_double_click", double_click, 1'b0);
    check1("rst_long_press", long_press, 1'b0);
    check1("rst_repeat_pulse", repeat_pulse, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single click: 3 high (arms), 5 low, release; 10th high sample closes the window.
    s = edge_n + 1;
    expect_ev(0, s + 17);
    seg(1'b1, 3);
    seg(1'b0, 1);
    check1("pressed_on_press", pressed, 1'b1);
    seg(1'b0, 4);
    seg(1'b1, 1);
    check1("pressed_on_release", pressed, 1'b0);
    seg(1'b1, 14);

    // Double click: low 3, high 4, low 3, high.
    s = edge_n + 1;
    expect_ev(1, s + 10);
    seg(1'b0, 3); seg(1'b1, 4); seg(1'b0, 3); seg(1'b1, 15);

    // Gap boundary: 9 high samples keep the window open.
    s = edge_n + 1;
    expect_ev(1, s + 15);
    seg(1'b0, 3); seg(1'b1, 9); seg(1'b0, 3); seg(1'b1, 15);

    // Gap boundary: 10 high samples close it; the next press starts a fresh click.
    s = edge_n + 1;
    expect_ev(0, s + 12);
    expect_ev(0, s + 25);
    seg(1'b0, 3); seg(1'b1, 10); seg(1'b0, 3); seg(1'b1, 15);

    // Long press: 30 low samples, long_press on the 20th, no click on release.
    s = edge_n + 1;
    expect_ev(2, s + 19);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(3, s + 24);
    expect_ev(3, s + 29);
`endif
    seg(1'b0, 30); seg(1'b1, 15);

    // Auto-repeat window: 32 low samples.
    s = edge_n + 1;
    expect_ev(2, s + 19);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(3, s + 24);
    expect_ev(3, s + 29);
`endif
    seg(1'b0, 32); seg(1'b1, 15);

    // Reset mid-press with the button held throughout: the aborted press emits nothing.
    seg(1'b0, 3);
    check1("pressed_before_reset", pressed, 1'b1);
    #2 rst_n = 1'b0;
    #1 check1("async_reset_pressed", pressed, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("pressed_in_reset", pressed, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      btn_level = 1'b0;
      @(negedge clk);
      check1("pressed_unarmed", pressed, 1'b0);
    end

    // Release 2 to arm, press 3, release: click on the 10th high sample.
    s = edge_n + 1;
    expect_ev(0, s + 14);
    seg(1'b1, 2);
    seg(1'b0, 3);
    check1("pressed_after_arm", pressed, 1'b1);
    seg(1'b1, 15);
    seg(1'b1, 5);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing %s: expected at edge %0d, never seen", kname(sb[0].kind), sb[0].at);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
